// File: rtl/clap_detector.sv
// clap_detector
//   Watches a multi-channel audio sample stream and declares a "clap" when
//   MIN_HITS consecutive accepted samples have at least one channel whose
//   magnitude is strictly above threshold. After a clap, HOLDOFF accepted
//   samples are ignored so that one acoustic event is counted only once.
//
// Optional feature: define CLAP_DETECTOR_DOUBLE_EN to add the double_clap
//   output. It pulses with clap_pulse when a clap is declared no more than
//   DOUBLE_WIN accepted samples after the previous clap.
//
// Ports
//   CLOCK_50           in   system clock, rising edge
//   resetn             in   asynchronous active-low reset
//   enable             in   detection enable; low forces IDLE and stops reads
//   threshold          in   unsigned magnitude threshold
//   audio_in_available in   upstream FIFO has a sample on every channel
//   audio_in           in   NUM_CH samples, channel 0 in the LSBs
//   read_audio_in      out  pop strobe; the sample is accepted while high
//   clap_pulse         out  one-cycle pulse, one cycle after the deciding read
//   clap_count         out  saturating clap counter
//   peak_level         out  largest magnitude since reset / clear_peak
//   clear_peak         in   synchronous clear of peak_level
//   busy               out  FSM is not IDLE
//   state_dbg          out  raw FSM state (0 IDLE, 1 ATTACK, 2 HOLD)
//   double_clap        out  (CLAP_DETECTOR_DOUBLE_EN only) double-clap pulse
//
// Handshake: a sample is consumed in every cycle where read_audio_in is high.
// read_audio_in = enable & audio_in_available & !(read last cycle), so pops
// are spaced at least two cycles apart and audio_in must be valid while
// audio_in_available is high.
module clap_detector #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int MIN_HITS   = 3,
  parameter int HOLDOFF    = 4800,
  parameter int CNT_W      = 8
`ifdef CLAP_DETECTOR_DOUBLE_EN
  ,
  parameter int DOUBLE_WIN = 24000
`endif
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic [DATA_WIDTH-1:0]        threshold,
  input  logic                         audio_in_available,
  input  logic [NUM_CH*DATA_WIDTH-1:0] audio_in,
  output logic                         read_audio_in,
  output logic                         clap_pulse,
  output logic [CNT_W-1:0]             clap_count,
  output logic [DATA_WIDTH-1:0]        peak_level,
  input  logic                         clear_peak,
  output logic                         busy,
  output logic [1:0]                   state_dbg
`ifdef CLAP_DETECTOR_DOUBLE_EN
  ,
  output logic                         double_clap
`endif
);

  localparam int HIT_W  = (MIN_HITS > 1) ? $clog2(MIN_HITS) : 1;
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_MAG  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ATTACK = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                state;
  logic [HIT_W-1:0]      hit_cnt;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  read_q;
  logic                  accept;
  logic                  hot;
  logic                  declare;
  logic [DATA_WIDTH-1:0] max_mag;
  logic [DATA_WIDTH-1:0] smp;
  logic [DATA_WIDTH-1:0] mag;

  // Gated with resetn so no pop is ever issued while reset is held.
  assign read_audio_in = resetn & enable & audio_in_available & ~read_q;
  assign accept        = read_audio_in;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;

  // Per-channel magnitude; the most negative code has no positive twin and
  // is clamped to the largest positive value.
  always_comb begin
    hot     = 1'b0;
    max_mag = '0;
    smp     = '0;
    mag     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      smp = audio_in[c*DATA_WIDTH +: DATA_WIDTH];
      if (smp == MOST_NEG)         mag = MAX_MAG;
      else if (smp[DATA_WIDTH-1])  mag = ~smp + 1'b1;
      else                         mag = smp;
      if (mag > threshold) hot = 1'b1;
      if (mag > max_mag)   max_mag = mag;
    end
  end

  // A clap is declared on the accepted hot sample that completes the run.
  always_comb begin
    declare = 1'b0;
    if (accept && hot) begin
      if (state == S_IDLE && MIN_HITS == 1)
        declare = 1'b1;
      else if (state == S_ATTACK && (int'(hit_cnt) + 1 >= MIN_HITS))
        declare = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      read_q <= 1'b0;
    end else begin
      read_q <= read_audio_in;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      peak_level <= '0;
    end else if (clear_peak) begin
      peak_level <= accept ? max_mag : '0;
    end else if (accept && max_mag > peak_level) begin
      peak_level <= max_mag;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      hit_cnt    <= '0;
      hold_cnt   <= '0;
      clap_pulse <= 1'b0;
      clap_count <= '0;
    end else begin
      clap_pulse <= 1'b0;
      if (declare) begin
        clap_pulse <= 1'b1;
        if (clap_count != '1) clap_count <= clap_count + 1'b1;
      end
      if (!enable) begin
        state    <= S_IDLE;
        hit_cnt  <= '0;
        hold_cnt <= '0;
      end else if (accept) begin
        case (state)
          S_IDLE: begin
            if (declare) begin
              state    <= S_HOLD;
              hold_cnt <= '0;
            end else if (hot) begin
              state   <= S_ATTACK;
              hit_cnt <= HIT_W'(1);
            end
          end
          S_ATTACK: begin
            if (declare) begin
              state    <= S_HOLD;
              hit_cnt  <= '0;
              hold_cnt <= '0;
            end else if (hot) begin
              hit_cnt <= hit_cnt + 1'b1;
            end else begin
              state   <= S_IDLE;
              hit_cnt <= '0;
            end
          end
          S_HOLD: begin
            // Level is ignored here; only the sample count matters.
            if (int'(hold_cnt) >= HOLDOFF - 1) begin
              state    <= S_IDLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            hit_cnt  <= '0;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef CLAP_DETECTOR_DOUBLE_EN
  localparam int WIN_W = $clog2(DOUBLE_WIN + 1);

  // gap_cnt counts accepted samples after the last clap and parks at
  // DOUBLE_WIN, which marks the window as expired.
  logic [WIN_W-1:0] gap_cnt;
  logic             have_prev;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      gap_cnt     <= '0;
      have_prev   <= 1'b0;
      double_clap <= 1'b0;
    end else begin
      double_clap <= 1'b0;
      if (declare) begin
        double_clap <= have_prev && (gap_cnt < WIN_W'(DOUBLE_WIN));
        have_prev   <= 1'b1;
        gap_cnt     <= '0;
      end else if (accept && gap_cnt < WIN_W'(DOUBLE_WIN)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clap_detector.sv
// tb_clap_detector
//   Self-checking bench for clap_detector (DATA_WIDTH=32, NUM_CH=2,
//   MIN_HITS=3, HOLDOFF=16, CNT_W=2, DOUBLE_WIN=100). A sample-level model
//   tracks the current hot run length and the number of samples still to be
//   ignored after a clap; every accepted sample is checked against it.
module tb_clap_detector;
  localparam int DW       = 32;
  localparam int NCH      = 2;
  localparam int MIN_HITS = 3;
  localparam int HOLDOFF  = 16;
  localparam int CNT_W    = 2;
  localparam int DWIN     = 100;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b0;
  logic [DW-1:0]     threshold = '0;
  logic              avail = 1'b0;
  logic [NCH*DW-1:0] audio_in = '0;
  logic              read_audio_in;
  logic              clap_pulse;
  logic [CNT_W-1:0]  clap_count;
  logic [DW-1:0]     peak_level;
  logic              clear_peak = 1'b0;
  logic              busy;
  logic [1:0]        state_dbg;
  logic              double_clap;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int          m_run, m_ignore, m_count;
  logic [DW-1:0] m_peak;
  longint      m_idx, m_last;
  bit          m_have_prev, exp_pulse, exp_double;
  logic [CNT_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef CLAP_DETECTOR_DOUBLE_EN
  clap_detector #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MIN_HITS(MIN_HITS),
                  .HOLDOFF(HOLDOFF), .CNT_W(CNT_W), .DOUBLE_WIN(DWIN)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable), .threshold(threshold),
    .audio_in_available(avail), .audio_in(audio_in),
    .read_audio_in(read_audio_in), .clap_pulse(clap_pulse),
    .clap_count(clap_count), .peak_level(peak_level),
    .clear_peak(clear_peak), .busy(busy), .state_dbg(state_dbg),
    .double_clap(double_clap));
`else
  clap_detector #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MIN_HITS(MIN_HITS),
                  .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable), .threshold(threshold),
    .audio_in_available(avail), .audio_in(audio_in),
    .read_audio_in(read_audio_in), .clap_pulse(clap_pulse),
    .clap_count(clap_count), .peak_level(peak_level),
    .clear_peak(clear_peak), .busy(busy), .state_dbg(state_dbg));
  assign double_clap = 1'b0;
`endif

  function automatic logic [DW-1:0] mag_of(input logic [DW-1:0] s);
    longint v;
    v = longint'($signed(s));
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_sample();
    int m;
    if ($urandom_range(0, 9) == 0) return 32'h8000_0000;
    m = int'($urandom_range(0, 6000));
    if ($urandom_range(0, 1) == 1) m = -m;
    return m;
  endfunction

  task automatic model_reset();
    m_run = 0; m_ignore = 0; m_count = 0; m_peak = '0;
    m_idx = 0; m_last = 0; m_have_prev = 0;
    exp_pulse = 0; exp_double = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                              input bit clr);
    logic [DW-1:0] a, b, mx;
    bit hot;
    a = mag_of(c0); b = mag_of(c1);
    mx  = (a > b) ? a : b;
    hot = (a > threshold) || (b > threshold);
    if (clr) m_peak = mx;
    else if (mx > m_peak) m_peak = mx;
    m_idx++;
    exp_pulse = 0; exp_double = 0;
    if (m_ignore > 0) begin
      m_ignore--;
      m_run = 0;
    end else if (hot) begin
      m_run++;
      if (m_run == MIN_HITS) begin
        exp_pulse = 1;
        if (m_count < (1 << CNT_W) - 1) m_count++;
        exp_q.push_back(CNT_W'(m_count));
`ifdef CLAP_DETECTOR_DOUBLE_EN
        exp_double = m_have_prev && (m_idx - m_last <= DWIN);
`endif
        m_last = m_idx; m_have_prev = 1;
        m_run = 0; m_ignore = HOLDOFF;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // driver: presents one sample, waits for the pop, checks the cycle after
  task automatic send_sample(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                             input bit clr, input int gap);
    int waited;
    avail = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (clap_pulse !== 1'b0 || double_clap !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_idle: clap_pulse=%b double_clap=%b required 0 0", clap_pulse, double_clap);
    end
    audio_in = {c1, c0}; avail = 1'b1; clear_peak = clr;
    #1;
    waited = 0;
    while (read_audio_in !== 1'b1 && waited < 4) begin
      @(negedge clk); #1; waited++;
    end
    n_checks++;
    if (read_audio_in !== 1'b1) begin
      n_fail++;
      $display("FAIL read_timeout: read_audio_in=%b required 1 within 4 cycles", read_audio_in);
      avail = 1'b0; clear_peak = 1'b0;
      return;
    end
    model_accept(c0, c1, clr);
    @(negedge clk);
    n_checks++;
    if (read_audio_in !== 1'b0) begin
      n_fail++;
      $display("FAIL read_spacing: read_audio_in=%b required 0 right after a pop", read_audio_in);
    end
    avail = 1'b0; clear_peak = 1'b0;
    n_checks++;
    if (clap_pulse !== exp_pulse) begin
      n_fail++;
      $display("FAIL clap_pulse: got %b required %b at sample %0d", clap_pulse, exp_pulse, m_idx);
    end
    if (clap_pulse === 1'b1 && exp_q.size() > 0) begin
      logic [CNT_W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (clap_count !== e) begin
        n_fail++;
        $display("FAIL pulse_count: got %0d required %0d", clap_count, e);
      end
    end
    n_checks++;
    if (clap_count !== CNT_W'(m_count)) begin
      n_fail++;
      $display("FAIL clap_count: got %0d required %0d", clap_count, m_count);
    end
    n_checks++;
    if (peak_level !== m_peak) begin
      n_fail++;
      $display("FAIL peak_level: got %h required %h", peak_level, m_peak);
    end
    n_checks++;
    if (busy !== (m_run > 0 || m_ignore > 0)) begin
      n_fail++;
      $display("FAIL busy: got %b required %b", busy, (m_run > 0 || m_ignore > 0));
    end
    n_checks++;
    if (double_clap !== exp_double) begin
      n_fail++;
      $display("FAIL double_clap: got %b required %b", double_clap, exp_double);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (read_audio_in !== 1'b0 || clap_pulse !== 1'b0 || clap_count !== '0 ||
        peak_level !== '0 || busy !== 1'b0 || double_clap !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rd=%b pulse=%b cnt=%0d peak=%h busy=%b dbl=%b required all 0",
               name, read_audio_in, clap_pulse, clap_count, peak_level, busy, double_clap);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0; avail = 1'b0; clear_peak = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic hot_run(input int n);
    for (int i = 0; i < n; i++) send_sample(32'd2000, 32'd0, 1'b0, 0);
  endtask

  task automatic cold_run(input int n);
    for (int i = 0; i < n; i++) send_sample(32'd5, 32'd0, 1'b0, 0);
  endtask

  // tests
  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; avail = 1'b1; threshold = 32'd1000;
    audio_in = {32'd0, 32'd2000};
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    avail = 1'b0;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_clap();
    apply_reset();
    threshold = 32'd1000;
    hot_run(3);
    n_checks++;
    if (clap_count !== 2'd1 || peak_level !== 32'd2000) begin
      n_fail++;
      $display("FAIL basic_clap: count=%0d peak=%0d required 1 2000", clap_count, peak_level);
    end
  endtask

  task automatic test_cold_break();
    apply_reset();
    threshold = 32'd1000;
    send_sample(32'd2000, 32'd0, 1'b0, 0);
    send_sample(32'd2000, 32'd0, 1'b0, 1);
    send_sample(32'd5, 32'd0, 1'b0, 0);
    n_checks++;
    if (busy !== 1'b0 || clap_count !== 2'd0 || peak_level !== 32'd2000) begin
      n_fail++;
      $display("FAIL cold_break: busy=%b count=%0d peak=%0d required 0 0 2000", busy, clap_count, peak_level);
    end
  endtask

  task automatic test_holdoff();
    apply_reset();
    threshold = 32'd1000;
    hot_run(3);
    hot_run(10);
    cold_run(6);
    n_checks++;
    if (clap_count !== 2'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL holdoff_window: count=%0d busy=%b required 1 0", clap_count, busy);
    end
    hot_run(3);
    n_checks++;
    if (clap_count !== 2'd2) begin
      n_fail++;
      $display("FAIL holdoff_second: count=%0d required 2", clap_count);
    end
  endtask

  task automatic test_most_negative();
    apply_reset();
    threshold = 32'd1000;
    for (int i = 0; i < 3; i++) send_sample(32'd0, 32'h8000_0000, 1'b0, 0);
    n_checks++;
    if (peak_level !== 32'h7FFF_FFFF || clap_count !== 2'd1) begin
      n_fail++;
      $display("FAIL most_negative: peak=%h count=%0d required 7fffffff 1", peak_level, clap_count);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    threshold = 32'd1000;
    for (int k = 0; k < 5; k++) begin
      hot_run(3);
      cold_run(HOLDOFF);
    end
    n_checks++;
    if (clap_count !== 2'd3) begin
      n_fail++;
      $display("FAIL count_saturate: count=%0d required 3", clap_count);
    end
  endtask

  task automatic test_reset_mid_attack();
    apply_reset();
    threshold = 32'd1000;
    hot_run(2);
    @(negedge clk);
    resetn = 1'b0; avail = 1'b1;
    #1;
    check_all_zero("reset_abort");
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset_abort_hold");
    end
    avail = 1'b0;
    resetn = 1'b1;
    model_reset();
    hot_run(1);
  endtask

  task automatic test_enable();
    apply_reset();
    threshold = 32'd1000;
    hot_run(3);
    cold_run(HOLDOFF);
    hot_run(2);
    @(negedge clk);
    enable = 1'b0; avail = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (read_audio_in !== 1'b0 || busy !== 1'b0 || clap_count !== 2'd1) begin
        n_fail++;
        $display("FAIL enable_low: rd=%b busy=%b count=%0d required 0 0 1", read_audio_in, busy, clap_count);
      end
    end
    avail = 1'b0;
    enable = 1'b1;
    m_run = 0; m_ignore = 0;
    hot_run(3);
  endtask

  task automatic test_clear_peak();
    apply_reset();
    threshold = 32'd1000;
    send_sample(32'd3000, 32'd0, 1'b0, 0);
    @(negedge clk);
    clear_peak = 1'b1;
    @(negedge clk);
    clear_peak = 1'b0;
    m_peak = '0;
    n_checks++;
    if (peak_level !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_peak_idle: peak=%0d required 0", peak_level);
    end
    send_sample(32'd700, 32'd0, 1'b0, 0);
    send_sample(32'd4000, 32'd0, 1'b0, 0);
    send_sample(32'd0, 32'hFFFF_FE0C, 1'b1, 0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) threshold = $urandom_range(0, 5000);
      send_sample(rand_sample(), rand_sample(), ($urandom_range(0, 29) == 0),
                  int'($urandom_range(0, 2)));
    end
  endtask

`ifdef CLAP_DETECTOR_DOUBLE_EN
  task automatic test_double();
    apply_reset();
    threshold = 32'd1000;
    hot_run(3);
    cold_run(47);
    hot_run(3);
    cold_run(197);
    hot_run(3);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_clap();
    test_cold_break();
    test_holdoff();
    test_most_negative();
    test_saturate();
    test_reset_mid_attack();
    test_enable();
    test_clear_peak();
    test_random();
`ifdef CLAP_DETECTOR_DOUBLE_EN
    test_double();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_claps: %0d expected claps never pulsed, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clap_detector.md
CLAP_DETECTOR -- requirements
Module: clap_detector

Interface
REQ-001 The module SHALL expose parameter DATA_WIDTH, default 32, signed two's-complement sample width per channel.
REQ-002 The module SHALL expose parameter NUM_CH, default 2, number of audio channels examined in parallel.
REQ-003 The module SHALL expose parameter MIN_HITS, default 3, consecutive over-threshold samples needed to declare a clap.
REQ-004 The module SHALL expose parameter HOLDOFF, default 4800, samples ignored after a clap (~0.1 s at 48 kHz).
REQ-005 The module SHALL expose parameter CNT_W, default 8, clap counter width.
REQ-006 CLOCK_50  input  1  system clock; all logic on rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  detection enable; low forces IDLE, no reads issued.
REQ-009 threshold  input  DATA_WIDTH  unsigned magnitude threshold, sampled every accepted sample.
REQ-010 audio_in_available  input  1  upstream FIFO holds a sample on every channel; data valid while high.
REQ-011 audio_in  input  NUM_CH*DATA_WIDTH  channel samples, channel 0 in LSBs.
REQ-012 read_audio_in  output  1  one-cycle pop strobe; the sample is accepted in the cycle it is high.
REQ-013 clap_pulse  output  1  one-cycle pulse per detected clap.
REQ-014 clap_count  output  CNT_W  total claps detected, saturating.
REQ-015 peak_level  output  DATA_WIDTH  largest magnitude seen since reset or clear_peak.
REQ-016 clear_peak  input  1  synchronous clear of peak_level.
REQ-017 busy  output  1  high when the FSM is not IDLE.

Function
REQ-018 read_audio_in SHALL be asserted iff enable=1, audio_in_available=1 and read_audio_in was low the previous cycle (at most one pop per two cycles).
REQ-019 Magnitude SHALL be |x| per channel; the most negative value SHALL saturate to 2^(DATA_WIDTH-1)-1.
REQ-020 A sample SHALL be "hot" when any channel magnitude is strictly greater than threshold.
REQ-021 FSM states SHALL be IDLE, ATTACK, HOLD; transitions evaluate only on accepted samples.
REQ-022 IDLE: hot sample -> ATTACK with hit_cnt=1; if MIN_HITS=1, clap is declared immediately and the FSM goes to HOLD.
REQ-023 ATTACK: hot sample increments hit_cnt; reaching MIN_HITS declares a clap -> HOLD with hold_cnt=0; cold sample -> IDLE, hit_cnt=0.
REQ-024 HOLD: every accepted sample increments hold_cnt regardless of level; at hold_cnt=HOLDOFF-1 -> IDLE.
REQ-025 clap_pulse SHALL assert in the cycle after the accepting read that declares the clap (latency 1).
REQ-026 clap_count SHALL increment with clap_pulse and hold at 2^CNT_W-1.
REQ-027 peak_level SHALL update to the maximum magnitude on every accepted sample; clear_peak coinciding with an accept SHALL load that sample's maximum magnitude.
REQ-028 enable falling SHALL return the FSM to IDLE and zero hit_cnt/hold_cnt next cycle; counters and peak_level retained.
REQ-029 audio_in_available dropping between pops SHALL stall the FSM without state change.

Reset
REQ-030 While resetn=0: read_audio_in=0, clap_pulse=0, clap_count=0, peak_level=0, busy=0, FSM=IDLE, internal counters 0.
REQ-031 Reset asserted mid-ATTACK or mid-HOLD SHALL abort immediately with no clap_pulse emitted.

Configuration
REQ-032 With macro CLAP_DETECTOR_DOUBLE_EN defined, output double_clap (1 bit) SHALL pulse one cycle when a clap is declared within DOUBLE_WIN (parameter, default 24000) accepted samples of the previous clap, otherwise it SHALL not exist.
REQ-033 Without CLAP_DETECTOR_DOUBLE_EN, the double-clap window counter SHALL not be synthesised and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, threshold=1000, 3 consecutive samples ch0=+2000 -> one clap_pulse after third read, clap_count=1, peak_level=2000.
REQ-035 Samples +2000, +2000, +5 (MIN_HITS=3) -> no clap_pulse, FSM back to IDLE, peak_level=2000.
REQ-036 Clap, then 10 hot samples inside HOLDOFF=16 -> clap_count stays 1; hot run after 16 samples -> clap_count=2.
REQ-037 ch1=-2^31 with DATA_WIDTH=32 -> magnitude 2^31-1, counted hot for threshold=1000; peak_level=0x7FFFFFFF.
REQ-038 CNT_W=2, five claps -> clap_count saturates at 3; resetn pulsed mid-ATTACK -> all outputs 0, no pulse.
REQ-039 CLAP_DETECTOR_DOUBLE_EN, DOUBLE_WIN=100, HOLDOFF=16: claps 50 samples apart -> double_clap pulses with second clap_pulse; 200 apart -> no double_clap.
